// File: rtl/round_pkg.sv
// Shared types and default constants for the Duck Hunt round scheduler.
// dog_mode_t is also used by draw_dog_ctl.
package round_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DOG_INTRO,
    FLY,
    REACT,
    ROUND_END,
    GAME_OVER
  } state_t;

  typedef enum logic [1:0] {
    INTRO = 2'd0,
    SHOW  = 2'd1,
    LAUGH = 2'd2
  } dog_mode_t;

  localparam int DEF_DUCKS_PER_ROUND = 10;
  localparam int DEF_MIN_HITS        = 6;
  localparam int DEF_SHOTS_PER_DUCK  = 3;
  localparam int DEF_FLIGHT_TIMEOUT  = 325_000_000;
  localparam int DEF_MAX_ROUND       = 99;

endpackage

// File: rtl/flight_timer.sv
// Duck flight timer: counts cycles while enabled, flags the last cycle before escape.
module flight_timer
  import round_pkg::*;
#(
  parameter int FLIGHT_TIMEOUT = DEF_FLIGHT_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int TW = $clog2(FLIGHT_TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(FLIGHT_TIMEOUT - 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/round_seq_ctl.sv
// Duck Hunt round scheduler: sequences dog animations and duck flights,
// counts shots/hits/ducks per round and advances or ends the game.
//
// state     | meaning
// IDLE      | waiting for game_enable
// DOG_INTRO | dog intro sequence running
// FLY       | duck in flight, shots counted, flight timer running
// REACT     | dog show/laugh sequence after a hit or miss
// ROUND_END | one-cycle decision: next round or game over
// GAME_OVER | counters frozen until game_enable drops
module round_seq_ctl
  import round_pkg::*;
#(
  parameter int DUCKS_PER_ROUND = DEF_DUCKS_PER_ROUND,
  parameter int MIN_HITS        = DEF_MIN_HITS,
  parameter int SHOTS_PER_DUCK  = DEF_SHOTS_PER_DUCK,
  parameter int FLIGHT_TIMEOUT  = DEF_FLIGHT_TIMEOUT,
  parameter int MAX_ROUND       = DEF_MAX_ROUND
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       game_enable_i,
  input  logic       shot_i,
  input  logic       duck_hit_i,
  input  logic       dog_done_i,
  output logic       dog_start_o,
  output logic [1:0] dog_mode_o,
  output logic       duck_start_o,
  output logic       duck_flee_o,
  output logic [1:0] shots_left_o,
  output logic [3:0] duck_idx_o,
  output logic [3:0] round_hits_o,
  output logic [7:0] round_num_o,
  output logic       game_over_o
);

  state_t    state_q, state_d;
  dog_mode_t dog_mode_q, dog_mode_d;
  logic      dog_start_q, dog_start_d;
  logic      duck_start_q, duck_start_d;
  logic      duck_flee_q, duck_flee_d;
  logic      game_over_q, game_over_d;
  logic [1:0] shots_q, shots_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] hits_q, hits_d;
  logic [7:0] round_q, round_d;
  logic [3:0] idx_inc;
  logic       expired;

  flight_timer #(
    .FLIGHT_TIMEOUT(FLIGHT_TIMEOUT)
  ) u_flight_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  ((state_q != FLY) || !game_enable_i),
    .enable_i (state_q == FLY),
    .expired_o(expired)
  );

  assign idx_inc = idx_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    dog_mode_d   = dog_mode_q;
    dog_start_d  = 1'b0;
    duck_start_d = 1'b0;
    duck_flee_d  = 1'b0;
    shots_d      = shots_q;
    idx_d        = idx_q;
    hits_d       = hits_q;
    round_d      = round_q;

    case (state_q)
      IDLE: begin
        state_d     = DOG_INTRO;
        dog_start_d = 1'b1;
        dog_mode_d  = INTRO;
      end
      DOG_INTRO: begin
        if (dog_done_i) begin
          state_d      = FLY;
          duck_start_d = 1'b1;
          shots_d      = 2'(SHOTS_PER_DUCK);
        end
      end
      FLY: begin
        if (shot_i && (shots_q != 2'd0)) begin
          shots_d = shots_q - 2'd1;
        end
        // A hit wins over a simultaneous last shot or timeout.
        if (duck_hit_i) begin
          hits_d      = hits_q + 4'd1;
          state_d     = REACT;
          dog_mode_d  = SHOW;
          dog_start_d = 1'b1;
        end else if ((shot_i && (shots_q == 2'd1)) || expired) begin
          duck_flee_d = 1'b1;
          dog_mode_d  = LAUGH;
          dog_start_d = 1'b1;
          state_d     = REACT;
        end
      end
      REACT: begin
        if (dog_done_i) begin
          idx_d = idx_inc;
          if (idx_inc == 4'(DUCKS_PER_ROUND)) begin
            state_d = ROUND_END;
          end else begin
            state_d      = FLY;
            duck_start_d = 1'b1;
            shots_d      = 2'(SHOTS_PER_DUCK);
          end
        end
      end
      ROUND_END: begin
        if (hits_q >= 4'(MIN_HITS)) begin
          if (round_q != 8'(MAX_ROUND)) begin
            round_d = round_q + 8'd1;
          end
          idx_d       = '0;
          hits_d      = '0;
          state_d     = DOG_INTRO;
          dog_start_d = 1'b1;
          dog_mode_d  = INTRO;
        end else begin
          state_d = GAME_OVER;
        end
      end
      GAME_OVER: state_d = GAME_OVER;
      default:   state_d = IDLE;
    endcase

    game_over_d = (state_d == GAME_OVER);

    // Dropping game_enable restores the reset picture from any state.
    if (!game_enable_i) begin
      state_d      = IDLE;
      dog_mode_d   = INTRO;
      dog_start_d  = 1'b0;
      duck_start_d = 1'b0;
      duck_flee_d  = 1'b0;
      shots_d      = '0;
      idx_d        = '0;
      hits_d       = '0;
      round_d      = 8'd1;
      game_over_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      dog_mode_q   <= INTRO;
      dog_start_q  <= 1'b0;
      duck_start_q <= 1'b0;
      duck_flee_q  <= 1'b0;
      game_over_q  <= 1'b0;
      shots_q      <= '0;
      idx_q        <= '0;
      hits_q       <= '0;
      round_q      <= 8'd1;
    end else begin
      state_q      <= state_d;
      dog_mode_q   <= dog_mode_d;
      dog_start_q  <= dog_start_d;
      duck_start_q <= duck_start_d;
      duck_flee_q  <= duck_flee_d;
      game_over_q  <= game_over_d;
      shots_q      <= shots_d;
      idx_q        <= idx_d;
      hits_q       <= hits_d;
      round_q      <= round_d;
    end
  end

  assign dog_start_o  = dog_start_q;
  assign dog_mode_o   = dog_mode_q;
  assign duck_start_o = duck_start_q;
  assign duck_flee_o  = duck_flee_q;
  assign shots_left_o = shots_q;
  assign duck_idx_o   = idx_q;
  assign round_hits_o = hits_q;
  assign round_num_o  = round_q;
  assign game_over_o  = game_over_q;

endmodule

// File: doc/round_seq_ctl.md
Name: round_seq_ctl

Overview:
Game-round scheduler for Duck Hunt. It sequences the dog animation controller (intro, show-duck and laugh sequences) and the duck flight controller, counts shots, hits and ducks per round, and advances or ends the game. It sits between the top-level game_enable/shot logic and the dog/duck controllers, in the 65 MHz pixel clock domain.

Parameters:
DUCKS_PER_ROUND, 10, ducks launched per round (1..15)
MIN_HITS, 6, hits required in a round to advance (<= DUCKS_PER_ROUND)
SHOTS_PER_DUCK, 3, shots available per duck (1..3)
FLIGHT_TIMEOUT, 325_000_000, clk cycles before an unhit duck escapes (5 s at 65 MHz)
MAX_ROUND, 99, round_num saturation value

Ports:
clk  in  1  65 MHz clock
rst  in  1  synchronous, active-high reset
game_enable  in  1  level; low aborts to IDLE
shot  in  1  one-cycle trigger pulse from the gun/mouse logic
duck_hit  in  1  one-cycle pulse from the duck controller: current duck shot
dog_done  in  1  one-cycle pulse from the dog controller: sequence finished
dog_start  out  1  one-cycle pulse: start the dog sequence selected by dog_mode
dog_mode  out  2  held: 0 INTRO, 1 SHOW, 2 LAUGH
duck_start  out  1  one-cycle pulse: launch a new duck
duck_flee  out  1  one-cycle pulse: current duck flies away
shots_left  out  2  remaining shots for the current duck
duck_idx  out  4  ducks completed in the current round
round_hits  out  4  hits in the current round
round_num  out  8  current round, starts at 1
game_over  out  1  high in GAME_OVER

Behaviour:
- Reset: state IDLE; all pulses 0; dog_mode 0; shots_left 0; duck_idx 0; round_hits 0; round_num 1; game_over 0; timer 0.
- Priority each cycle: rst > game_enable low (go to IDLE next cycle, same values as reset, from any state) > FSM.
- All outputs are registered. A pulse is asserted in the cycle after the triggering condition and lasts exactly one cycle.
- IDLE: when game_enable=1, go to DOG_INTRO, pulse dog_start, dog_mode=INTRO.
- DOG_INTRO: on dog_done, go to FLY, pulse duck_start, shots_left=SHOTS_PER_DUCK, timer=0.
- FLY: timer increments each cycle.
  - duck_hit: round_hits+1; if shot is also high that cycle, also decrement shots_left. Go to REACT with dog_mode=SHOW and pulse dog_start. Hit takes priority over every miss condition.
  - shot without hit: shots_left-1, saturating at 0.
  - Miss: shot with shots_left==1 and no hit, or timer==FLIGHT_TIMEOUT-1. Pulse duck_flee and dog_start with dog_mode=LAUGH, then go to REACT.
  - shot while shots_left==0 is ignored.
- REACT: shot and duck_hit are ignored. On dog_done, duck_idx+1.
  - If the new duck_idx==DUCKS_PER_ROUND, go to ROUND_END.
  - Otherwise go to FLY: pulse duck_start, reload shots_left, clear timer.
- ROUND_END (one cycle):
  - If round_hits>=MIN_HITS: round_num+1 (saturates at MAX_ROUND); clear duck_idx and round_hits; go to DOG_INTRO and pulse dog_start with INTRO.
  - Otherwise go to GAME_OVER.
- GAME_OVER: game_over=1 and all counters hold. Leaving requires game_enable to go low (abort rule).
- dog_done outside DOG_INTRO/REACT is ignored. Events arriving in the same cycle as a state transition belong to the old state only.
- Timer width is $clog2(FLIGHT_TIMEOUT+1). Counter widths are as declared; no wrap, because the parameter ranges bound them.

Decomposition:
- round_pkg:
  - state_t enum: IDLE, DOG_INTRO, FLY, REACT, ROUND_END, GAME_OVER
  - dog_mode_t enum: INTRO=0, SHOW=1, LAUGH=2
  - default parameter constants
  - dog_mode_t is shared with draw_dog_ctl.
- Sub-module flight_timer: clear/enable inputs, expired output at FLIGHT_TIMEOUT-1.

Test Plan:
(bench parameters: DUCKS_PER_ROUND=2, MIN_HITS=1, SHOTS_PER_DUCK=3, FLIGHT_TIMEOUT=100)
1. Reset and start: rst 5 cycles, then game_enable=1 → dog_start pulse one cycle later, dog_mode=0, round_num=1, all counters 0.
2. Hit path: dog_done → duck_start, shots_left=3. One shot → shots_left=2. duck_hit with shot in the same cycle → round_hits=1, shots_left=1, dog_mode=1, dog_start pulse.
3. Miss by shots: three shots with no hit → shots_left 3,2,1, then duck_flee and dog_start with dog_mode=2. dog_done → duck_idx increments.
4. Timeout: no shots for 100 cycles after duck_start → duck_flee on the timeout cycle. A fourth shot during REACT has no effect.
5. Round advance vs game over: 1 hit in 2 ducks → round_num=2, counters cleared, INTRO dog_start. 0 hits → game_over=1 held. game_enable low → IDLE, game_over=0, round_num=1.
6. Abort mid-FLY: game_enable low with shots_left=2 → next cycle all outputs at reset values. rst during REACT → same result.
